// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: drives one external 1-bit full adder LSB first, WIDTH clocks per add.
// Latency: done pulses WIDTH clocks after the edge that accepts start; result held until next accept.
// Backpressure: start is sampled only in IDLE; requests in RUN/DONE are dropped, not queued.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, op_a, op_b,  request and operands; operands/carry-in latched on accepted start
//   cin
//   fa_A                to adder cell: {a_bit, b_bit, carry_bit}, zero outside RUN
//   fa_sum, fa_cry      from adder cell: sum and carry of fa_A
//   busy                high for the WIDTH cycles of RUN
//   done                one-cycle result-valid pulse (DONE state)
//   sum, cout           result and final carry, updated only at the last RUN edge
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic [2:0]       fa_A,
    input  logic             fa_sum,
    input  logic             fa_cry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             c_reg;
    logic [CW-1:0]    cnt;

    logic accept;
    logic run;
    logic last_bit;

    assign accept   = (state == S_IDLE) && start;
    assign run      = (state == S_RUN);
    assign last_bit = run && (cnt == LAST);

    assign busy = run;
    assign done = (state == S_DONE);
    // The adder cell sees zeros whenever it is not being used.
    assign fa_A = run ? {a_sh[0], b_sh[0], c_reg} : 3'b000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start)    state_nxt = S_RUN;
            S_RUN:  if (last_bit) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            c_reg  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sh   <= op_a;
            b_sh   <= op_b;
            c_reg  <= cin;
            cnt    <= '0;
            res_sh <= '0;
        end else if (run) begin
            // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
            res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
            c_reg  <= fa_cry;
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            if (!last_bit) begin
                cnt <= cnt + 1'b1;
            end
            // Publish on the last bit directly from the cell so sum is ready in the DONE cycle.
            if (last_bit) begin
                sum  <= {fa_sum, res_sh[WIDTH-1:1]};
                cout <= fa_cry;
            end
        end
    end

endmodule
